// File: rtl/spi_ram_if.sv
// ---------------------------------------------------------------------------
// spi_ram_if
// Word-level link between the SPI slave and the command-decoding RAM.
//   din      : received 10-bit SPI word, [9:8] command, [7:0] payload
//   rx_valid : din valid (level, may stay high for many cycles)
//   dout     : read data returned to the SPI slave
//   tx_valid : one-cycle pulse marking a fresh dout
//   err      : sticky protocol-error flag
// master = SPI slave side (drives din/rx_valid), slave = RAM side.
// ---------------------------------------------------------------------------
interface spi_ram_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output err
    );
endinterface

// File: rtl/spi_ram.sv
// ---------------------------------------------------------------------------
// spi_ram
// Single-port synchronous RAM driven by 10-bit SPI command words.
// Commands (din[9:8]): 00 load write address, 01 write data,
//                      10 load read address,  11 read data.
// A command is taken once per rising edge of rx_valid.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : spi_ram_if.slave (din, rx_valid in; dout, tx_valid, err out)
// All outputs come straight from flops; the memory array has no reset.
// ---------------------------------------------------------------------------
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_ram_if.slave bus
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic                 rx_valid_q;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_addr_vld_q, wr_addr_vld_d;
    logic                 rd_addr_vld_q, rd_addr_vld_d;
    logic [7:0]           dout_q, dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 err_q, err_d;

    logic                 accept_s;
    logic                 in_range_s;
    logic                 mem_we_s;

    logic [7:0]           mem_q [MEM_DEPTH];

    // Post-increment an address, wrapping the last word back to zero.
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (a == LAST_ADDR) begin
            return {ADDR_SIZE{1'b0}};
        end else begin
            return a + ADDR_SIZE'(1);
        end
    endfunction

    // Rising-edge detect on rx_valid and payload range check.
    always_comb begin
        accept_s   = bus.rx_valid & ~rx_valid_q;
        // Full 8-bit payload is compared so stray high bits count as out of range.
        in_range_s = ({24'd0, bus.din[7:0]} < 32'(MEM_DEPTH));
    end

    // Command decode: next-state for address, data and status registers.
    always_comb begin
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_vld_d = wr_addr_vld_q;
        rd_addr_vld_d = rd_addr_vld_q;
        dout_d        = dout_q;
        tx_valid_d    = 1'b0;
        err_d         = err_q;
        mem_we_s      = 1'b0;

        if (accept_s) begin
            case (bus.din[9:8])
                CMD_WR_ADDR: begin
                    if (in_range_s) begin
                        wr_addr_d     = bus.din[ADDR_SIZE-1:0];
                        wr_addr_vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_WR_DATA: begin
                    if (wr_addr_vld_q) begin
                        mem_we_s = 1'b1;
                        if (AUTO_INC) begin
                            wr_addr_d = next_addr(wr_addr_q);
                        end else begin
                            wr_addr_d = wr_addr_q;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    if (in_range_s) begin
                        rd_addr_d     = bus.din[ADDR_SIZE-1:0];
                        rd_addr_vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    if (rd_addr_vld_q) begin
                        dout_d     = mem_q[rd_addr_q];
                        tx_valid_d = 1'b1;
                        if (AUTO_INC) begin
                            rd_addr_d = next_addr(rd_addr_q);
                        end else begin
                            rd_addr_d = rd_addr_q;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end else begin
            tx_valid_d = 1'b0;
        end
    end

    // Control/status state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q    <= 1'b0;
            wr_addr_q     <= {ADDR_SIZE{1'b0}};
            rd_addr_q     <= {ADDR_SIZE{1'b0}};
            wr_addr_vld_q <= 1'b0;
            rd_addr_vld_q <= 1'b0;
            dout_q        <= 8'h00;
            tx_valid_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rx_valid_q    <= bus.rx_valid;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_vld_q <= wr_addr_vld_d;
            rd_addr_vld_q <= rd_addr_vld_d;
            dout_q        <= dout_d;
            tx_valid_q    <= tx_valid_d;
            err_q         <= err_d;
        end
    end

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_addr_q] <= bus.din[7:0];
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;

endmodule

// File: doc/spi_ram.md
Name: spi_ram

Overview:
- Single-port synchronous RAM that sits directly downstream of the SPI slave and consumes its 10-bit received words (rx_data / rx_valid).
- Decodes the 2-bit command prefix of each word to load the write address, write data, load the read address, or read data.
- Read data goes back to the SPI slave on dout / tx_valid, where it is serialised onto MISO.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; must be ≤ 2^ADDR_SIZE.
- ADDR_SIZE, 8, address width taken from din[ADDR_SIZE-1:0]; must be ≤ 8.
- AUTO_INC, 0, when 1 the write address (after a write-data command) and the read address (after a read-data command) post-increment, wrapping MEM_DEPTH-1 → 0.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  10  received SPI word: [9:8] command, [7:0] payload.
- rx_valid  input  1  din valid; level signal from the SPI slave, may stay high for many cycles.
- dout  output  8  read data to the SPI slave.
- tx_valid  output  1  dout valid pulse.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0) forces these values immediately:
  - dout=0, tx_valid=0, err=0.
  - wr_addr=0, rd_addr=0, wr_addr_vld=0, rd_addr_vld=0, rx_valid_q=0.
  - Memory array is NOT reset; contents are undefined until written.
- Command acceptance:
  - A command is accepted only on a rising edge of rx_valid: rx_valid=1 and rx_valid_q=0 at a posedge clk.
  - rx_valid_q registers rx_valid every cycle.
  - rx_valid held high produces exactly one command; rx_valid must drop before the next command.
- Command decode (din[9:8]), each acting at the accepting posedge:
  - 00 write-addr: wr_addr ← din[ADDR_SIZE-1:0]; wr_addr_vld ← 1.
  - 01 write-data:
    - If wr_addr_vld=1: mem[wr_addr] ← din[7:0]; if AUTO_INC=1, wr_addr ← wr_addr+1, wrapping MEM_DEPTH-1 → 0.
    - If wr_addr_vld=0: no write, err ← 1.
  - 10 read-addr: rd_addr ← din[ADDR_SIZE-1:0]; rd_addr_vld ← 1.
  - 11 read-data:
    - If rd_addr_vld=1: dout ← mem[rd_addr]; tx_valid ← 1 for exactly one cycle; if AUTO_INC=1, rd_addr ← rd_addr+1 with wrap.
    - If rd_addr_vld=0: dout unchanged, tx_valid stays 0, err ← 1.
    - din[7:0] is ignored.
- Out-of-range address:
  - A 00 or 10 command with payload ≥ MEM_DEPTH sets err ← 1.
  - The corresponding address register and its valid flag are left unchanged.
- Read latency:
  - Read-data command accepted at posedge N → dout and tx_valid=1 visible after posedge N; tx_valid returns to 0 after posedge N+1.
  - dout holds its value until the next successful read-data command or reset.
- Address persistence:
  - wr_addr and rd_addr persist across commands.
  - Repeated 01 without a new 00 writes the same address (AUTO_INC=0) or successive addresses (AUTO_INC=1).
- Read-after-write:
  - A write-data and a later read-data to the same address return the newly written byte.
  - Commands are at least 2 cycles apart by construction, so no same-cycle hazard exists.
- err is sticky and cleared only by rst_n.
- Reset mid-operation:
  - A tx_valid pulse in flight is killed.
  - Address valid flags are cleared, so a subsequent 01 or 11 without a fresh address sets err.
- Implementation structure:
  - No combinational path from din or rx_valid to any output.
  - All state is updated on posedge clk / negedge rst_n.

Test Plan:
- Reset, then rx_valid pulse din=0x0_2A (00), then din=0x1_5C (01), then din=0x2_2A (10), then din=0x3_00 (11) → dout=0x5C, tx_valid high exactly 1 cycle after acceptance, err=0.
- din=0x0_10 with rx_valid held high for 12 cycles, then din=0x1_77 with rx_valid held high for 12 cycles → exactly one write, mem[0x10]=0x77; read back confirms; no extra writes to 0x11.
- After reset, send 11 then 01 with no address loaded → tx_valid never asserts, dout=0, err=1 and stays 1 until rst_n.
- AUTO_INC=1: addr 0xFF, write 0xA1, 0xA2 → mem[0xFF]=0xA1, mem[0x00]=0xA2 (wrap); read addr 0xFF, two reads → dout 0xA1 then 0xA2.
- MEM_DEPTH=128: write-addr payload 0x90 → err=1, wr_addr unchanged; following 01 writes the previous valid address, or sets err if none was loaded.
- Assert rst_n=0 during the tx_valid cycle of a read → tx_valid and dout drop to 0 immediately; a post-reset read-data without read-addr sets err=1.
